// File: rtl/tick_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tick_period_meter
// Brief    : Measures clk cycles between tick rising edges, reports the period,
//            and flags lock against the expected rate or loss of tick.
// Revision : 1.0
// ============================================================================
module tick_period_meter #(
    parameter int CNT_W    = 25,
    parameter int EXP_FPGA = 15_000_001,
    parameter int EXP_ASIC = 1_250_001,
    parameter int TOL      = 4,
    parameter int LOCK_N   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             is_FPGA,
    input  logic             tick_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout_err
);

    localparam int                  STREAK_W = $clog2(LOCK_N + 1);
    localparam logic [STREAK_W-1:0] LOCK_V   = STREAK_W'(LOCK_N);
    localparam logic [CNT_W-1:0]    TOL_V    = CNT_W'(TOL);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2
    } state_t;

    state_t              state, state_n;
    logic                tick_q;
    logic                rise;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [STREAK_W-1:0] streak, streak_n, streak_inc;
    logic [CNT_W-1:0]    period_n;
    logic                period_valid_n, locked_n, timeout_err_n;
    logic [CNT_W-1:0]    exp_sel, exp_twice, good_lo, good_hi;
    logic                good;

    assign rise       = tick_in & ~tick_q;
    assign exp_sel    = is_FPGA ? CNT_W'(EXP_FPGA) : CNT_W'(EXP_ASIC);
    assign exp_twice  = exp_sel + exp_sel;
    assign good_lo    = exp_sel - TOL_V;
    assign good_hi    = exp_sel + TOL_V;
    assign good       = (cnt >= good_lo) && (cnt <= good_hi);
    // Streak saturates at LOCK_N so a long run of good periods never wraps.
    assign streak_inc = (streak == LOCK_V) ? LOCK_V : streak + STREAK_W'(1);

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        streak_n       = streak;
        period_n       = period;
        period_valid_n = 1'b0;
        locked_n       = locked;
        timeout_err_n  = 1'b0;
        if (!en) begin
            state_n  = IDLE;
            cnt_n    = '0;
            streak_n = '0;
            locked_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_n    = '0;
                    streak_n = '0;
                    locked_n = 1'b0;
                    state_n  = WAIT_FIRST;
                end
                WAIT_FIRST: begin
                    if (rise) begin
                        cnt_n   = CNT_W'(1);
                        state_n = MEASURE;
                    end
                end
                MEASURE: begin
                    // A rise on the same cycle as the timeout limit still counts as a period.
                    if (rise) begin
                        period_n       = cnt;
                        period_valid_n = 1'b1;
                        cnt_n          = CNT_W'(1);
                        if (good) begin
                            streak_n = streak_inc;
                            locked_n = (streak_inc == LOCK_V);
                        end else begin
                            streak_n = '0;
                            locked_n = 1'b0;
                        end
                    end else if (cnt == exp_twice) begin
                        timeout_err_n = 1'b1;
                        streak_n      = '0;
                        locked_n      = 1'b0;
                        cnt_n         = '0;
                        state_n       = WAIT_FIRST;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            tick_q       <= 1'b0;
            cnt          <= '0;
            streak       <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_n;
            tick_q       <= tick_in;
            cnt          <= cnt_n;
            streak       <= streak_n;
            period       <= period_n;
            period_valid <= period_valid_n;
            locked       <= locked_n;
            timeout_err  <= timeout_err_n;
        end
    end

endmodule
`default_nettype wire
